// File: rtl/axi_i2c_pkg.sv
// Shared types and constants for the AXI4-Lite to I2C write front end.
//   resp_t     : AXI write response encoding (BRESP)
//   fe_state_t : front-end transaction state
//   I2C_*      : bit positions of the I2C fields inside AWADDR / WDATA
package axi_i2c_pkg;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_EXOKAY = 2'b01,
    RESP_SLVERR = 2'b10,
    RESP_DECERR = 2'b11
  } resp_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_RESP
  } fe_state_t;

  // AWADDR[14:8] = 7-bit device address, AWADDR[7:0] = register pointer.
  localparam int I2C_DEV_W    = 7;
  localparam int I2C_DEV_LSB  = 8;
  localparam int I2C_DEV_MSB  = I2C_DEV_LSB + I2C_DEV_W - 1;
  localparam int I2C_REG_W    = 8;
  localparam int I2C_REG_LSB  = 0;
  localparam int I2C_DATA_W   = 8;
  // First AWADDR bit that must be zero for the address to decode.
  localparam int I2C_ADDR_TOP = I2C_DEV_MSB + 1;

endpackage

// File: rtl/axi_i2c_wr_frontend_if.sv
// AXI4-Lite write channels (AW, W, B) between an AXI master and the front end.
//   master modport : drives AWVALID/AWADDR, WVALID/WDATA, BREADY
//   slave  modport : drives AWREADY, WREADY, BVALID/BRESP
interface axi_i2c_wr_frontend_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int RESP_WIDTH = 2
);

  logic                  AWVALID;
  logic                  AWREADY;
  logic [ADDR_WIDTH-1:0] AWADDR;
  logic                  WVALID;
  logic                  WREADY;
  logic [DATA_WIDTH-1:0] WDATA;
  logic                  BVALID;
  logic                  BREADY;
  logic [RESP_WIDTH-1:0] BRESP;

  modport master (
    output AWVALID, AWADDR, WVALID, WDATA, BREADY,
    input  AWREADY, WREADY, BVALID, BRESP
  );

  modport slave (
    input  AWVALID, AWADDR, WVALID, WDATA, BREADY,
    output AWREADY, WREADY, BVALID, BRESP
  );

endinterface

// File: rtl/i2c_wdog_timer.sv
// Watchdog counter for an outstanding I2C command.
//   clk, rst_n : clock, asynchronous active-low reset
//   clear      : force the count back to zero (has priority over enable)
//   enable     : count one cycle
//   expired    : count has reached TIMEOUT_CYC-1
module i2c_wdog_timer #(
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CNT_W = $clog2(TIMEOUT_CYC);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYC - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  assign expired = (cnt_q == LAST);

  // Saturates at LAST so a missed clear can never wrap into a fresh window.
  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable && !expired) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/axi_i2c_wr_frontend.sv
// AXI4-Lite write slave feeding the I2C master engine.
// Joins AW and W beats (any order), decodes the I2C target, issues one
// byte-write command, waits for completion or timeout and returns BRESP.
// One transaction outstanding at a time.
//   ACLK, ARESETn : clock, asynchronous active-low reset (shared with engine)
//   axi           : AXI4-Lite write channels (slave side)
//   cmd_valid/ready, cmd_dev/reg/data : command handshake to the engine
//   cmd_done, cmd_nack : completion pulse and its NACK qualifier
//   cmd_abort     : one-cycle pulse telling the engine to abandon the command
module axi_i2c_wr_frontend
  import axi_i2c_pkg::*;
#(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int RESP_WIDTH  = 2,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic                  ACLK,
  input  logic                  ARESETn,
  axi_i2c_wr_frontend_if.slave  axi,
  output logic                  cmd_valid,
  input  logic                  cmd_ready,
  output logic [I2C_DEV_W-1:0]  cmd_dev,
  output logic [I2C_REG_W-1:0]  cmd_reg,
  output logic [I2C_DATA_W-1:0] cmd_data,
  input  logic                  cmd_done,
  input  logic                  cmd_nack,
  output logic                  cmd_abort
);

  fe_state_t state_q, state_d;
  logic      aw_held_q, aw_held_d;
  logic      w_held_q, w_held_d;
  logic      awready_q, awready_d;
  logic      wready_q, wready_d;
  logic      decerr_q, decerr_d;
  logic [I2C_DEV_W-1:0]  dev_q, dev_d;
  logic [I2C_REG_W-1:0]  reg_q, reg_d;
  logic [I2C_DATA_W-1:0] data_q, data_d;
  resp_t     bresp_q, bresp_d;

  logic aw_fire;
  logic w_fire;
  logic both_held;
  logic b_fire;
  logic wdog_expired;

  // Only the low byte of WDATA travels to the engine.
  logic [DATA_WIDTH-1:0] wdata_all;
  logic                  unused_wdata;
  assign wdata_all    = axi.WDATA;
  assign unused_wdata = ^wdata_all;

  assign aw_fire   = axi.AWVALID && awready_q;
  assign w_fire    = axi.WVALID && wready_q;
  assign both_held = aw_held_q && w_held_q;
  assign b_fire    = (state_q == ST_RESP) && axi.BREADY;

  i2c_wdog_timer #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_wdog (
    .clk     (ACLK),
    .rst_n   (ARESETn),
    .clear   (state_q != ST_WAIT),
    .enable  (state_q == ST_WAIT),
    .expired (wdog_expired)
  );

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (both_held) state_d = decerr_q ? ST_RESP : ST_ISSUE;
      ST_ISSUE: if (cmd_ready) state_d = ST_WAIT;
      // A completion in the expiry cycle still counts as completion.
      ST_WAIT:  if (cmd_done || wdog_expired) state_d = ST_RESP;
      ST_RESP:  if (axi.BREADY) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Capture flags, command fields and response
  always_comb begin
    aw_held_d = aw_held_q | aw_fire;
    w_held_d  = w_held_q | w_fire;
    decerr_d  = decerr_q;
    dev_d     = dev_q;
    reg_d     = reg_q;
    data_d    = data_q;
    bresp_d   = bresp_q;

    if (aw_fire) begin
      decerr_d = |axi.AWADDR[ADDR_WIDTH-1:I2C_ADDR_TOP];
      dev_d    = axi.AWADDR[I2C_DEV_MSB:I2C_DEV_LSB];
      reg_d    = axi.AWADDR[I2C_REG_LSB +: I2C_REG_W];
    end
    if (w_fire) begin
      data_d = wdata_all[I2C_DATA_W-1:0];
    end

    case (state_q)
      ST_IDLE: if (both_held && decerr_q) bresp_d = RESP_DECERR;
      ST_WAIT: begin
        if (cmd_done)          bresp_d = cmd_nack ? RESP_SLVERR : RESP_OKAY;
        else if (wdog_expired) bresp_d = RESP_SLVERR;
      end
      default: ;
    endcase

    if (b_fire) begin
      aw_held_d = 1'b0;
      w_held_d  = 1'b0;
      bresp_d   = RESP_OKAY;
    end

    // READYs are registered: they drop the cycle after a capture and
    // reassert the cycle after the B handshake.
    awready_d = (state_d == ST_IDLE) && !aw_held_d;
    wready_d  = (state_d == ST_IDLE) && !w_held_d;
  end

  // Outputs
  always_comb begin
    cmd_valid = (state_q == ST_ISSUE);
    cmd_abort = (state_q == ST_WAIT) && wdog_expired && !cmd_done;
  end

  assign axi.AWREADY = awready_q;
  assign axi.WREADY  = wready_q;
  assign axi.BVALID  = (state_q == ST_RESP);
  assign axi.BRESP   = RESP_WIDTH'(bresp_q);
  assign cmd_dev     = dev_q;
  assign cmd_reg     = reg_q;
  assign cmd_data    = data_q;

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state_q   <= ST_IDLE;
      aw_held_q <= 1'b0;
      w_held_q  <= 1'b0;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      decerr_q  <= 1'b0;
      dev_q     <= '0;
      reg_q     <= '0;
      data_q    <= '0;
      bresp_q   <= RESP_OKAY;
    end else begin
      state_q   <= state_d;
      aw_held_q <= aw_held_d;
      w_held_q  <= w_held_d;
      awready_q <= awready_d;
      wready_q  <= wready_d;
      decerr_q  <= decerr_d;
      dev_q     <= dev_d;
      reg_q     <= reg_d;
      data_q    <= data_d;
      bresp_q   <= bresp_d;
    end
  end

endmodule

// File: tb/tb_axi_i2c_wr_frontend.sv
// Directed bench for axi_i2c_wr_frontend (TIMEOUT_CYC = 16).
module tb_axi_i2c_wr_frontend;

  localparam int TO = 16;

  logic       clk = 1'b0;
  logic       ARESETn;
  logic       cmd_valid, cmd_ready, cmd_done, cmd_nack, cmd_abort;
  logic [6:0] cmd_dev;
  logic [7:0] cmd_reg, cmd_data;

  always #5 clk = ~clk;

  axi_i2c_wr_frontend_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .RESP_WIDTH(2)) axi ();

  axi_i2c_wr_frontend #(
    .ADDR_WIDTH (32),
    .DATA_WIDTH (32),
    .RESP_WIDTH (2),
    .TIMEOUT_CYC(TO)
  ) dut (
    .ACLK     (clk),
    .ARESETn  (ARESETn),
    .axi      (axi),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_dev  (cmd_dev),
    .cmd_reg  (cmd_reg),
    .cmd_data (cmd_data),
    .cmd_done (cmd_done),
    .cmd_nack (cmd_nack),
    .cmd_abort(cmd_abort)
  );

  int checks   = 0;
  int failures = 0;

  // Handshake counters observed on the clock edge
  int aw_beats = 0, w_beats = 0, cmd_acc = 0, abort_cnt = 0, cv_cycles = 0;
  always @(posedge clk) begin
    if (ARESETn === 1'b1) begin
      if (axi.AWVALID && axi.AWREADY) aw_beats  <= aw_beats + 1;
      if (axi.WVALID && axi.WREADY)   w_beats   <= w_beats + 1;
      if (cmd_valid && cmd_ready)     cmd_acc   <= cmd_acc + 1;
      if (cmd_abort)                  abort_cnt <= abort_cnt + 1;
      if (cmd_valid)                  cv_cycles <= cv_cycles + 1;
    end
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] all_outs();
    return {2'b00, axi.AWREADY, axi.WREADY, axi.BVALID, axi.BRESP,
            cmd_valid, cmd_abort, cmd_dev, cmd_reg, cmd_data};
  endfunction

  task automatic send_aw(input string tag, input logic [31:0] addr);
    logic got = 1'b0;
    axi.AWADDR  = addr;
    axi.AWVALID = 1'b1;
    for (int i = 0; i < 40; i++) begin
      if (axi.AWREADY) begin
        tick();
        got = 1'b1;
        break;
      end
      tick();
    end
    axi.AWVALID = 1'b0;
    check_val({tag, "_aw_hs"}, got, 1);
  endtask

  task automatic send_w(input string tag, input logic [31:0] data);
    logic got = 1'b0;
    axi.WDATA  = data;
    axi.WVALID = 1'b1;
    for (int i = 0; i < 40; i++) begin
      if (axi.WREADY) begin
        tick();
        got = 1'b1;
        break;
      end
      tick();
    end
    axi.WVALID = 1'b0;
    check_val({tag, "_w_hs"}, got, 1);
  endtask

  task automatic wait_cmd(input string tag);
    logic got = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (cmd_valid) begin
        got = 1'b1;
        break;
      end
      tick();
    end
    check_val({tag, "_cmd_valid"}, got, 1);
  endtask

  // Accept the pending command, then complete it on the next cycle.
  task automatic engine_done(input logic nack);
    cmd_ready = 1'b1;
    tick();
    cmd_ready = 1'b0;
    cmd_done  = 1'b1;
    cmd_nack  = nack;
    tick();
    cmd_done  = 1'b0;
    cmd_nack  = 1'b0;
  endtask

  task automatic finish_resp(input string tag, input logic [1:0] exp_resp);
    logic got = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (axi.BVALID) begin
        got = 1'b1;
        break;
      end
      tick();
    end
    check_val({tag, "_bvalid"}, got, 1);
    check_val({tag, "_bresp"}, axi.BRESP, exp_resp);
    axi.BREADY = 1'b1;
    tick();
    axi.BREADY = 1'b0;
    check_val({tag, "_bvalid_drop"}, axi.BVALID, 0);
  endtask

  initial begin
    logic early;
    int   cv0;

    ARESETn     = 1'b0;
    axi.AWVALID = 1'b0;
    axi.AWADDR  = '0;
    axi.WVALID  = 1'b0;
    axi.WDATA   = '0;
    axi.BREADY  = 1'b0;
    cmd_ready   = 1'b0;
    cmd_done    = 1'b0;
    cmd_nack    = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check_val("rst_outputs", all_outs(), 0);
    ARESETn = 1'b1;
    tick();
    check_val("rdy_after_rst", {axi.AWREADY, axi.WREADY}, 2'b11);

    // T1: AW, then W three cycles later
    send_aw("t1", 32'h0000_5010);
    check_val("t1_aw_rdy_drop", {axi.AWREADY, axi.WREADY}, 2'b01);
    tick();
    tick();
    send_w("t1", 32'h0000_00A5);
    check_val("t1_no_cmd_yet", cmd_valid, 0);
    tick();
    check_val("t1_cmd_valid", cmd_valid, 1);
    check_val("t1_fields", {cmd_dev, cmd_reg, cmd_data}, {7'h50, 8'h10, 8'hA5});
    tick();
    tick();
    check_val("t1_hold", {cmd_valid, cmd_dev, cmd_reg, cmd_data}, {1'b1, 7'h50, 8'h10, 8'hA5});
    engine_done(1'b0);
    check_val("t1_bvalid_lat", axi.BVALID, 1);
    finish_resp("t1", 2'b00);
    check_val("t1_rdy_back", {axi.AWREADY, axi.WREADY}, 2'b11);

    // T2: W before AW
    send_w("t2", 32'h0000_003C);
    check_val("t2_w_rdy_drop", {axi.AWREADY, axi.WREADY}, 2'b10);
    tick();
    send_aw("t2", 32'h0000_2A01);
    wait_cmd("t2");
    check_val("t2_fields", {cmd_dev, cmd_reg, cmd_data}, {7'h2A, 8'h01, 8'h3C});
    engine_done(1'b0);
    finish_resp("t2", 2'b00);
    check_val("t2_beats", {aw_beats[15:0], w_beats[15:0]}, {16'd2, 16'd2});

    // T3: AW and W in the same cycle, VALIDs left high; minimum latency
    axi.AWADDR  = 32'h0000_7FFF;
    axi.WDATA   = 32'hFFFF_FF00;
    axi.AWVALID = 1'b1;
    axi.WVALID  = 1'b1;
    tick();
    check_val("t3_no_cmd_yet", cmd_valid, 0);
    tick();
    check_val("t3_cmd_valid", cmd_valid, 1);
    check_val("t3_fields", {cmd_dev, cmd_reg, cmd_data}, {7'h7F, 8'hFF, 8'h00});
    cmd_ready = 1'b1;
    tick();
    cmd_ready = 1'b0;
    cmd_done  = 1'b1;
    tick();
    cmd_done  = 1'b0;
    check_val("t3_min_lat", axi.BVALID, 1);
    axi.AWVALID = 1'b0;
    axi.WVALID  = 1'b0;
    finish_resp("t3", 2'b00);
    check_val("t3_beats", {aw_beats[15:0], w_beats[15:0]}, {16'd3, 16'd3});
    check_val("t3_cmd_count", cmd_acc, 3);

    // T4: decode errors (bit 16, then bit 15)
    cv0 = cv_cycles;
    send_aw("t4", 32'h0001_0000);
    send_w("t4", 32'h0000_0011);
    finish_resp("t4", 2'b11);
    send_aw("t4b", 32'h0000_8000);
    send_w("t4b", 32'h0000_0022);
    finish_resp("t4b", 2'b11);
    check_val("t4_no_cmd", cv_cycles, cv0);

    // T5: NACK
    send_aw("t5", 32'h0000_4422);
    send_w("t5", 32'h0000_0077);
    wait_cmd("t5");
    engine_done(1'b1);
    finish_resp("t5", 2'b10);

    // T6: timeout -> abort exactly TO cycles after accept
    send_aw("t6", 32'h0000_1234);
    send_w("t6", 32'h0000_0056);
    wait_cmd("t6");
    cmd_ready = 1'b1;
    tick();
    cmd_ready = 1'b0;
    early = 1'b0;
    for (int k = 1; k < TO; k++) begin
      early = early | cmd_abort | axi.BVALID;
      tick();
    end
    check_val("t6_no_early_abort", early, 0);
    check_val("t6_abort", cmd_abort, 1);
    tick();
    check_val("t6_abort_pulse", cmd_abort, 0);
    finish_resp("t6", 2'b10);
    check_val("t6_abort_count", abort_cnt, 1);

    // T7: done in the expiry cycle wins
    send_aw("t7", 32'h0000_0102);
    send_w("t7", 32'h0000_0003);
    wait_cmd("t7");
    cmd_ready = 1'b1;
    tick();
    cmd_ready = 1'b0;
    repeat (TO - 1) tick();
    cmd_done = 1'b1;
    #1;
    check_val("t7_no_abort", cmd_abort, 0);
    tick();
    cmd_done = 1'b0;
    finish_resp("t7", 2'b00);
    check_val("t7_abort_count", abort_cnt, 1);

    // T8: BREADY held low for 10 cycles
    send_aw("t8", 32'h0000_3300);
    send_w("t8", 32'h0000_0099);
    wait_cmd("t8");
    engine_done(1'b1);
    for (int k = 0; k < 10; k++) begin
      check_val("t8_b_stable", {axi.BVALID, axi.BRESP, axi.AWREADY, axi.WREADY}, 5'b1_10_00);
      tick();
    end
    finish_resp("t8", 2'b10);

    // T9: asynchronous reset in the middle of WAIT
    send_aw("t9", 32'h0000_6E42);
    send_w("t9", 32'h0000_00C3);
    wait_cmd("t9");
    cmd_ready = 1'b1;
    tick();
    cmd_ready = 1'b0;
    tick();
    tick();
    check_val("t9_fields", {cmd_dev, cmd_reg, cmd_data}, {7'h6E, 8'h42, 8'hC3});
    check_val("t9_cmd_count", cmd_acc, 8);
    #2;
    ARESETn = 1'b0;
    #1;
    check_val("t9_async_rst", all_outs(), 0);
    @(posedge clk);
    #1;
    ARESETn = 1'b1;
    tick();
    check_val("t9_recover", {axi.AWREADY, axi.WREADY, axi.BVALID}, 3'b110);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
